// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped branch target buffer with per-entry saturating
// counters for the fetch stage. Lookup is combinational from pc_IF; resolved
// branches/jumps write back one record per cycle. Entry arrays carry no reset
// and are cleared by an init sweep after rst and on flush_all.
// Optional feature macro: BPU_PERF_EN (update / mispredict counters).
module bpu_btb #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned TAG_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_IF,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            busy,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_branch,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
  input  logic            flush_all,
  output logic [31:0]     perf_updates,
  output logic [31:0]     perf_mispredicts
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = IDX_W + 1 + TAG_WIDTH;

  localparam logic [CNT_WIDTH-1:0] CNT_WNT = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CNT_WT  = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_MIN = {CNT_WIDTH{1'b0}};
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(ENTRIES - 1);

  // Elaboration-time parameter sanity
  generate
    if ((ENTRIES < 2) || ((1 << IDX_W) != ENTRIES)) begin : gBadEntries
      $error("bpu_btb: ENTRIES must be a power of two and >= 2");
    end
    if (XLEN < IDX_W + 2 + TAG_WIDTH) begin : gBadTag
      $error("bpu_btb: XLEN too small for IDX_W+2+TAG_WIDTH");
    end
    if (CNT_WIDTH < 2) begin : gBadCnt
      $error("bpu_btb: CNT_WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] sweepIdx;

  // Entry storage, no reset so it can map onto SRAM macros
  logic                 validArr  [ENTRIES];
  logic [TAG_WIDTH-1:0] tagArr    [ENTRIES];
  logic [XLEN-1:0]      targetArr [ENTRIES];
  logic [CNT_WIDTH-1:0] cntArr    [ENTRIES];
  logic                 jumpArr   [ENTRIES];

  logic                 running;
  logic                 restart;

  logic [IDX_W-1:0]     lkIdx;
  logic [TAG_WIDTH-1:0] lkTag;
  logic                 lkHit;

  logic [IDX_W-1:0]     upIdx;
  logic [TAG_WIDTH-1:0] upTag;
  logic                 upHit;
  logic                 upAccept;
  logic                 upTaken;
  logic [CNT_WIDTH-1:0] upCnt;
  logic [CNT_WIDTH-1:0] upCntNext;

  assign running = (state == RUN);
  assign restart = rst | flush_all;
  assign busy    = (state == INIT);

  // Sweep FSM: rst/flush_all restart at index 0, last cleared index enters RUN
  always_ff @(posedge clk) begin
    if (restart) begin
      state    <= INIT;
      sweepIdx <= '0;
    end else if (state == INIT) begin
      sweepIdx <= sweepIdx + IDX_W'(1);
      if (sweepIdx == IDX_LAST) begin
        state <= RUN;
      end
    end
  end

  assign lkIdx = pc_IF[IDX_W+1:2];
  assign lkTag = pc_IF[TAG_HI:TAG_LO];

  // Fetch-side lookup; no bypass from a same-cycle update
  always_comb begin
    lkHit       = running & validArr[lkIdx] & (tagArr[lkIdx] == lkTag);
    pred_taken  = lkHit & (jumpArr[lkIdx] | cntArr[lkIdx][CNT_WIDTH-1]);
    pred_target = pred_taken ? targetArr[lkIdx] : (pc_IF + XLEN'(4));
  end

  assign upIdx = upd_pc[IDX_W+1:2];
  assign upTag = upd_pc[TAG_HI:TAG_LO];

  // Update-side decode and saturating counter step
  always_comb begin
    upHit     = validArr[upIdx] & (tagArr[upIdx] == upTag);
    upAccept  = running & upd_valid & ~restart & (upd_is_branch | upd_is_jump);
    upTaken   = upd_is_jump | upd_taken;
    upCnt     = cntArr[upIdx];
    upCntNext = upCnt;
    if (upd_taken) begin
      if (upCnt != CNT_MAX) upCntNext = upCnt + CNT_WIDTH'(1);
    end else begin
      if (upCnt != CNT_MIN) upCntNext = upCnt - CNT_WIDTH'(1);
    end
  end

  // Array writes: sweep clear during INIT, resolution write-back during RUN
  always_ff @(posedge clk) begin
    if ((state == INIT) && !restart) begin
      validArr[sweepIdx] <= 1'b0;
      cntArr[sweepIdx]   <= CNT_WNT;
    end else if (upAccept) begin
      if (upHit) begin
        if (upd_is_jump) begin
          targetArr[upIdx] <= upd_target;
        end else begin
          cntArr[upIdx] <= upCntNext;
          if (upd_taken) targetArr[upIdx] <= upd_target;
        end
      end else if (upTaken) begin
        validArr[upIdx]  <= 1'b1;
        tagArr[upIdx]    <= upTag;
        targetArr[upIdx] <= upd_target;
        jumpArr[upIdx]   <= upd_is_jump;
        cntArr[upIdx]    <= CNT_WT;
      end
    end
  end

`ifdef BPU_PERF_EN
  logic [31:0] perfUpd;
  logic [31:0] perfMis;

  // Wrapping event counters, cleared by rst only
  always_ff @(posedge clk) begin
    if (rst) begin
      perfUpd <= '0;
      perfMis <= '0;
    end else if (upAccept) begin
      perfUpd <= perfUpd + 32'd1;
      if (upd_mispredict) perfMis <= perfMis + 32'd1;
    end
  end

  assign perf_updates     = perfUpd;
  assign perf_mispredicts = perfMis;
`else
  logic unusedMispredict;

  assign perf_updates     = '0;
  assign perf_mispredicts = '0;
  assign unusedMispredict = upd_mispredict;
`endif

  // PC bits outside the index/tag fields are intentionally ignored
  logic unusedPcBits;
  assign unusedPcBits = ^{pc_IF, upd_pc};

endmodule
